// File: rtl/lsu_dmem_responder.sv
// rtl/lsu_dmem_responder.sv - single-outstanding local data RAM responder with fixed wait states
//
// Accepts one load/store request at a time, performs the RAM access at the
// accept edge, then acknowledges after WAIT_STATES extra cycles.
//
// Ports:
//   clk_i           - clock, rising edge
//   rst_ni          - asynchronous active-low reset
//   mem_addr_i      - request byte address (bits [1:0] ignored)
//   mem_data_wr_i   - write data
//   mem_rd_i        - read request
//   mem_wr_i        - byte-lane write enables, bit n enables byte n
//   mem_req_tag_i   - request tag
//   mem_accept_o    - responder can take a request this cycle
//   mem_ack_o       - one-cycle response strobe
//   mem_error_o     - error flag, valid with mem_ack_o
//   mem_resp_tag_o  - tag of the acknowledged request
//   mem_data_rd_o   - read data, valid with mem_ack_o
module lsu_dmem_responder #(
  parameter int MEM_WORDS   = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_wr_i,
  input  logic        mem_rd_i,
  input  logic [3:0]  mem_wr_i,
  input  logic [10:0] mem_req_tag_i,
  output logic        mem_accept_o,
  output logic        mem_ack_o,
  output logic        mem_error_o,
  output logic [10:0] mem_resp_tag_o,
  output logic [31:0] mem_data_rd_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_e      state_q, state_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic        ack_q;
  logic        err_q;
  logic [10:0] tag_q;
  logic [31:0] rdata_q;
  logic [31:0] ram_q [MEM_WORDS];

  logic              req_present;
  logic              req_accept;
  logic              req_error;
  logic              addr_oob;
  logic [ADDR_W-1:0] word_idx;

  assign req_present = mem_rd_i | (|mem_wr_i);
  // Gated by rst_ni so a request sitting on the bus during reset cannot write RAM.
  assign req_accept  = req_present & mem_accept_o & rst_ni;
  assign addr_oob    = (mem_addr_i >> (ADDR_W + 2)) != 32'd0;
  assign req_error   = addr_oob | (mem_rd_i & (|mem_wr_i));
  assign word_idx    = mem_addr_i[ADDR_W+1:2];

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_accept) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 3'd0) begin
          state_d = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_accept_o   = (state_q == ST_IDLE);
    mem_ack_o      = ack_q;
    mem_error_o    = err_q;
    mem_resp_tag_o = tag_q;
    mem_data_rd_o  = rdata_q;
  end

  // Response registers. The ack is registered out of RESP, so it lands in the
  // cycle after the RESP->IDLE edge while the responder is already accepting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      tag_q   <= 11'd0;
      rdata_q <= 32'd0;
    end else begin
      ack_q <= (state_q == ST_RESP);
      if (req_accept) begin
        tag_q   <= mem_req_tag_i;
        err_q   <= req_error;
        rdata_q <= (!req_error && mem_rd_i) ? ram_q[word_idx] : 32'd0;
      end
    end
  end

  // RAM: not reset; writes land at the accept edge.
  always_ff @(posedge clk_i) begin
    if (req_accept && !req_error) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wr_i[b]) begin
          ram_q[word_idx][8*b +: 8] <= mem_data_wr_i[8*b +: 8];
        end
      end
    end
  end

endmodule
